// File: rtl/ms_es_mul_job_ctrl.sv
// Job sequencer around a deterministic stochastic multiplier: one pending job
// buffer, CLEAR/RUN/FLUSH sequencing of the multiplier, and a held result port.
module ms_es_mul_job_ctrl #(
  parameter int DATA_WIDTH   = 5,
  parameter int NUM_INPUTS   = 2,
  parameter int RES_W        = 10,
  parameter int CLR_CYCLES   = 2,
  parameter int MIN_RUN      = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 11
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic                             mul_rst,
  output logic                             mul_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_bin_in,
  input  logic [RES_W-1:0]                 mul_result,
  input  logic                             mul_done,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RES_W-1:0]                 out_data,
  output logic [CNT_W-1:0]                 out_cycles,
  output logic                             out_timeout
);

  localparam int OPW = NUM_INPUTS * DATA_WIDTH;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_RUN_C = CNT_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] FL_LAST   = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_CAPTURE, S_OUT
  } state_t;

  state_t           state, state_nx;
  logic             pend_full;
  logic [OPW-1:0]   pend_data;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] ph_cnt;
  logic             to_flag;
  logic             accept, pull, done_ok, at_limit, ph_last;

  assign in_ready = ~pend_full;
  assign accept   = in_valid & ~pend_full;
  assign pull     = (state == S_IDLE) & pend_full;
  // done is combinational and may glitch while the SNGs start; honour it only
  // once the run has lasted MIN_RUN cycles
  assign done_ok  = mul_done & (run_cnt >= MIN_RUN_C);
  assign at_limit = (run_cnt == TO_LAST);

  always_comb begin
    ph_last = 1'b0;
    case (state)
      S_CLEAR: ph_last = (ph_cnt == CLR_LAST);
      S_FLUSH: ph_last = (ph_cnt == FL_LAST);
      default: ph_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (pull) state_nx = S_CLEAR;
      S_CLEAR:   if (ph_last) state_nx = S_RUN;
      S_RUN:     if (done_ok || at_limit) state_nx = S_FLUSH;
      S_FLUSH:   if (ph_last) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_OUT;
      S_OUT:     if (out_ready) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mul_rst   = 1'b0;
    mul_en    = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE, S_CLEAR: mul_rst   = 1'b1;
      S_RUN:           mul_en    = 1'b1;
      S_OUT:           out_valid = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full   <= 1'b0;
      pend_data   <= '0;
      mul_bin_in  <= '0;
      run_cnt     <= '0;
      ph_cnt      <= '0;
      to_flag     <= 1'b0;
      out_data    <= '0;
      out_cycles  <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (accept) begin
        pend_full <= 1'b1;
        pend_data <= in_data;
      end else if (pull) begin
        pend_full <= 1'b0;
      end

      if (pull) mul_bin_in <= pend_data;

      if ((state == S_CLEAR || state == S_FLUSH) && !ph_last) ph_cnt <= ph_cnt + ONE;
      else                                                     ph_cnt <= '0;

      // run_cnt ends at the number of RUN cycles, TIMEOUT at most
      if (state == S_CLEAR) begin
        run_cnt <= '0;
      end else if (state == S_RUN) begin
        if (run_cnt != TO_MAX) run_cnt <= run_cnt + ONE;
        if (done_ok || at_limit) to_flag <= ~done_ok;
      end

      if (state == S_CAPTURE) begin
        out_data    <= mul_result;
        out_cycles  <= run_cnt;
        out_timeout <= to_flag;
      end
    end
  end

endmodule

// File: tb/tb_ms_es_mul_job_ctrl.sv
// Directed bench for ms_es_mul_job_ctrl with a behavioural multiplier that
// raises done after a programmable number of enabled cycles.
module tb_ms_es_mul_job_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data;
  logic        mul_rst;
  logic        mul_en;
  logic [9:0]  mul_bin_in;
  logic [9:0]  mul_result;
  logic        mul_done;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic [10:0] out_cycles;
  logic        out_timeout;

  int vectors = 0;
  int miscompares = 0;
  int en_cnt = 0;
  int done_at = 7;
  int glitch_at = -1;
  bit done_in_clear = 1'b0;
  bit seen;

  ms_es_mul_job_ctrl #(
    .DATA_WIDTH(5), .NUM_INPUTS(2), .RES_W(10), .CLR_CYCLES(2),
    .MIN_RUN(2), .FLUSH_CYCLES(2), .TIMEOUT(1024), .CNT_W(11)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_bin_in(mul_bin_in), .mul_result(mul_result), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cycles(out_cycles), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  // Multiplier model: done during the enabled cycle numbered done_at (1-based);
  // before that the accumulator shows en_cnt/2 as a partial value.
  always @(posedge clk) begin
    if (mul_rst)     en_cnt <= 0;
    else if (mul_en) en_cnt <= en_cnt + 1;
  end

  always_comb begin
    mul_done = done_in_clear && mul_rst;
    if (mul_en && done_at > 0 && en_cnt == done_at - 1) mul_done = 1'b1;
    if (mul_en && glitch_at >= 0 && en_cnt == glitch_at) mul_done = 1'b1;
    if (done_at > 0 && en_cnt >= done_at)
      mul_result = {5'd0, mul_bin_in[4:0]} * {5'd0, mul_bin_in[9:5]};
    else
      mul_result = 10'(en_cnt / 2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] a, input logic [4:0] b, input string tag);
    in_data  = {b, a};
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) break;
      step();
    end
    chk({tag, " accept"}, in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_valid) break;
      step();
    end
    chk({tag, " valid"}, out_valid, 1);
  endtask

  task automatic check_out(input string tag, input int d, input int c, input int t);
    chk({tag, " data"}, out_data, d);
    chk({tag, " cycles"}, out_cycles, c);
    chk({tag, " timeout"}, out_timeout, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step(); step();
    chk("rst in_ready", in_ready, 1);
    chk("rst mul_rst", mul_rst, 1);
    chk("rst mul_en", mul_en, 0);
    chk("rst mul_bin_in", mul_bin_in, 0);
    chk("rst out_valid", out_valid, 0);
    check_out("rst", 0, 0, 0);
    rst = 1'b1;
    step();

    // single job, latency and clear length
    send(5'd16, 5'd16, "t1");
    chk("t1 c1 mul_rst", mul_rst, 1);
    chk("t1 c1 mul_en", mul_en, 0);
    step();
    chk("t1 c2 mul_rst", mul_rst, 1);
    chk("t1 c2 mul_en", mul_en, 0);
    chk("t1 operands", mul_bin_in, {5'd16, 5'd16});
    step();
    chk("t1 c3 mul_rst", mul_rst, 1);
    chk("t1 c3 mul_en", mul_en, 0);
    step();
    chk("t1 c4 mul_rst", mul_rst, 0);
    chk("t1 c4 mul_en", mul_en, 1);
    repeat (9) step();
    chk("t1 c13 out_valid", out_valid, 0);
    step();
    chk("t1 c14 out_valid", out_valid, 1);
    check_out("t1", 256, 7, 0);
    step();
    chk("t1 release", out_valid, 0);

    // done glitches in CLEAR and first run cycle are ignored
    done_at = 5; glitch_at = 0; done_in_clear = 1'b1;
    send(5'd6, 5'd7, "t2");
    wait_valid("t2", 60);
    check_out("t2", 42, 5, 0);
    step();
    done_in_clear = 1'b0; glitch_at = -1;

    // done never arrives: abort with partial result
    done_at = 0;
    send(5'd2, 5'd3, "t3");
    wait_valid("t3", 1200);
    check_out("t3", 512, 1024, 1);
    step();

    // done honoured exactly at MIN_RUN, ignored one cycle before
    done_at = 3; glitch_at = 1;
    send(5'd3, 5'd4, "t3b");
    wait_valid("t3b", 60);
    check_out("t3b", 12, 3, 0);
    step();
    glitch_at = -1;

    // three jobs under output backpressure
    done_at = 7; out_ready = 1'b0;
    send(5'd3, 5'd5, "t4 j1");
    send(5'd7, 5'd9, "t4 j2");
    chk("t4 j2 held", in_ready, 0);
    in_data = {5'd31, 5'd31};
    in_valid = 1'b1;
    wait_valid("t4 j1", 60);
    check_out("t4 j1", 15, 7, 0);
    repeat (20) begin
      step();
      chk("t4 stall valid", out_valid, 1);
      chk("t4 stall data", out_data, 15);
      chk("t4 stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4 j1 drop", out_valid, 0);
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      step();
    end
    chk("t4 j3 accept", in_ready, 1);
    step();
    in_valid = 1'b0;
    wait_valid("t4 j2", 60);
    check_out("t4 j2", 63, 7, 0);
    repeat (5) begin
      step();
      chk("t4 j2 stall data", out_data, 63);
      chk("t4 j2 stall valid", out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    wait_valid("t4 j3", 60);
    check_out("t4 j3", 961, 7, 0);
    step();

    // reset in the middle of RUN with a pending job
    done_at = 0;
    send(5'd4, 5'd5, "t5 j1");
    send(5'd6, 5'd7, "t5 j2");
    for (int i = 0; i < 20; i++) begin
      if (mul_en) break;
      step();
    end
    chk("t5 running", mul_en, 1);
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    chk("t5 rst out_valid", out_valid, 0);
    chk("t5 rst mul_rst", mul_rst, 1);
    chk("t5 rst mul_en", mul_en, 0);
    chk("t5 rst in_ready", in_ready, 1);
    chk("t5 rst mul_bin_in", mul_bin_in, 0);
    check_out("t5 rst", 0, 0, 0);
    step(); step();
    rst = 1'b1;
    done_at = 7;
    seen = 1'b0;
    repeat (30) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("t5 no stale result", seen, 0);
    send(5'd2, 5'd3, "t5 new");
    wait_valid("t5 new", 60);
    check_out("t5 new", 6, 7, 0);
    step();

    // second job accepted right after the first is pulled
    done_at = 3;
    send(5'd5, 5'd6, "t6 a");
    send(5'd9, 5'd10, "t6 b");
    chk("t6 b pending", in_ready, 0);
    wait_valid("t6 a", 60);
    check_out("t6 a", 30, 3, 0);
    step();
    wait_valid("t6 b", 60);
    check_out("t6 b", 90, 3, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
